// File: rtl/raster_stamp_fetch_pkg.sv
// Shared types for the raster stamp fetch stage: stamp record, fetch FSM
// states, and the latched request echo returned with the response.
// Latency: n/a (types only). Backpressure: n/a.
package raster_stamp_fetch_pkg;

    localparam int UUID_WIDTH      = 44;
    localparam int NW_WIDTH        = 2;
    localparam int NR_BITS         = 5;
    localparam int XLEN            = 32;
    localparam int NUM_THREADS     = 4;
    localparam int PERF_CTR_BITS   = 44;
    localparam int RASTER_POS_BITS = 15;

    // Index width that never collapses to zero bits.
    function automatic int log2up(input int x);
        return (x > 1) ? $clog2(x) : 1;
    endfunction

    // The response echo is sized for the widest legal lane/packet split so a
    // single type serves every NUM_LANES configuration.
    localparam int FETCH_TMASK_W = NUM_THREADS;
    localparam int FETCH_PID_W   = log2up(NUM_THREADS);

    typedef struct packed {
        logic [RASTER_POS_BITS-1:0] pos_x;
        logic [RASTER_POS_BITS-1:0] pos_y;
        logic [3:0]                 mask;
    } raster_stamp_t;

    typedef enum logic [1:0] {
        FETCH_IDLE = 2'd0,
        FETCH_WAIT = 2'd1,
        FETCH_RESP = 2'd2
    } raster_fetch_state_e;

    typedef struct packed {
        logic [UUID_WIDTH-1:0]    uuid;
        logic [NW_WIDTH-1:0]      wid;
        logic [FETCH_TMASK_W-1:0] tmask;
        logic [FETCH_PID_W-1:0]   pid;
        logic [NR_BITS-1:0]       rd;
    } raster_fetch_rsp_t;

endpackage

// File: rtl/raster_fetch_fsm.sv
// Control for one raster-fetch request: accept, wait for a stamp group or
// exhaustion, then hold the response. Outputs are registered; write and
// response assert together 2 cycles after accept. Holds in RESP until rsp_ready.
// Ports: request/raster/response handshakes in, registered ready/valid/write
// strobes out, plus combinational fire strobes for the top's datapath latches.
module raster_fetch_fsm
    import raster_stamp_fetch_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic req_valid_i,
    input  logic raster_valid_i,
    input  logic raster_done_i,
    input  logic rsp_ready_i,
    input  logic hit_any_i,
    output logic req_ready_o,
    output logic raster_ready_o,
    output logic write_enable_o,
    output logic rsp_valid_o,
    output logic req_fire_o,
    output logic consume_o,
    output logic done_fire_o
);

    raster_fetch_state_e state_q;
    logic req_ready_q;
    logic raster_ready_q;
    logic write_enable_q;
    logic rsp_valid_q;

    assign req_fire_o  = req_valid_i && req_ready_q;
    assign consume_o   = raster_valid_i && raster_ready_q;
    // A valid group always takes priority over the exhaustion level.
    assign done_fire_o = raster_done_i && !raster_valid_i && raster_ready_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= FETCH_IDLE;
            req_ready_q    <= 1'b1;
            raster_ready_q <= 1'b0;
            write_enable_q <= 1'b0;
            rsp_valid_q    <= 1'b0;
        end else begin
            // Write strobe is a single-cycle pulse on the WAIT->RESP edge.
            write_enable_q <= 1'b0;
            case (state_q)
                FETCH_IDLE: begin
                    if (req_fire_o) begin
                        state_q        <= FETCH_WAIT;
                        req_ready_q    <= 1'b0;
                        raster_ready_q <= 1'b1;
                    end
                end
                FETCH_WAIT: begin
                    if (consume_o || done_fire_o) begin
                        state_q        <= FETCH_RESP;
                        raster_ready_q <= 1'b0;
                        rsp_valid_q    <= 1'b1;
                        write_enable_q <= consume_o && hit_any_i;
                    end
                end
                FETCH_RESP: begin
                    if (rsp_ready_i) begin
                        state_q     <= FETCH_IDLE;
                        rsp_valid_q <= 1'b0;
                        req_ready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q        <= FETCH_IDLE;
                    req_ready_q    <= 1'b1;
                    raster_ready_q <= 1'b0;
                    rsp_valid_q    <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready_o    = req_ready_q;
    assign raster_ready_o = raster_ready_q;
    assign write_enable_o = write_enable_q;
    assign rsp_valid_o    = rsp_valid_q;

endmodule

// File: rtl/raster_stamp_fetch.sv
// Raster fetch stage: pulls one stamp group per SFU request, writes hit lanes
// to the raster CSR store and returns per-lane stamp-present to the SFU.
// Latency: write and response 2 cycles after accept; holds response until rsp_ready.
// Ports: req_* (SFU request), raster_* (stamp stream), write_* (CSR store
// write port), rsp_* (SFU result). Optional RASTER_FETCH_PERF_EN adds
// perf_stall_cycles and perf_stamps counters.
module raster_stamp_fetch
    import raster_stamp_fetch_pkg::*;
#(
    parameter int CORE_ID   = 0,
    parameter int NUM_LANES = 1,
    parameter int PID_WIDTH = log2up(NUM_THREADS / NUM_LANES)
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              req_valid,
    input  logic [UUID_WIDTH-1:0]             req_uuid,
    input  logic [NW_WIDTH-1:0]               req_wid,
    input  logic [NUM_LANES-1:0]              req_tmask,
    input  logic [PID_WIDTH-1:0]              req_pid,
    input  logic [NR_BITS-1:0]                req_rd,
    output logic                              req_ready,
    input  logic                              raster_valid,
    input  raster_stamp_t [NUM_LANES-1:0]     raster_stamps,
    input  logic [NUM_LANES-1:0]              raster_mask,
    input  logic                              raster_done,
    output logic                              raster_ready,
    output logic                              write_enable,
    output logic [UUID_WIDTH-1:0]             write_uuid,
    output logic [NW_WIDTH-1:0]               write_wid,
    output logic [NUM_LANES-1:0]              write_tmask,
    output logic [PID_WIDTH-1:0]              write_pid,
    output raster_stamp_t [NUM_LANES-1:0]     write_data,
`ifdef RASTER_FETCH_PERF_EN
    output logic [PERF_CTR_BITS-1:0]          perf_stall_cycles,
    output logic [PERF_CTR_BITS-1:0]          perf_stamps,
`endif
    output logic                              rsp_valid,
    output logic [UUID_WIDTH-1:0]             rsp_uuid,
    output logic [NW_WIDTH-1:0]               rsp_wid,
    output logic [NUM_LANES-1:0]              rsp_tmask,
    output logic [PID_WIDTH-1:0]              rsp_pid,
    output logic [NR_BITS-1:0]                rsp_rd,
    output logic [NUM_LANES-1:0][XLEN-1:0]    rsp_data,
    input  logic                              rsp_ready
);

    logic req_fire;
    logic consume;
    logic done_fire;
    logic [NUM_LANES-1:0] lane_hit;

    raster_fetch_rsp_t rsp_q, rsp_d;
    logic [NUM_LANES-1:0] hit_q, hit_d;
    raster_stamp_t [NUM_LANES-1:0] stamps_q, stamps_d;

    // Upper tmask/pid bits of the shared echo type are zero for narrow configs.
    logic unused_rsp_bits;
    assign unused_rsp_bits = ^rsp_q;

    // Lanes outside the request mask never hit; their stamps are dropped.
    assign lane_hit = rsp_q.tmask[NUM_LANES-1:0] & raster_mask;

    raster_fetch_fsm u_fsm (
        .clk            (clk),
        .reset          (reset),
        .req_valid_i    (req_valid),
        .raster_valid_i (raster_valid),
        .raster_done_i  (raster_done),
        .rsp_ready_i    (rsp_ready),
        .hit_any_i      (|lane_hit),
        .req_ready_o    (req_ready),
        .raster_ready_o (raster_ready),
        .write_enable_o (write_enable),
        .rsp_valid_o    (rsp_valid),
        .req_fire_o     (req_fire),
        .consume_o      (consume),
        .done_fire_o    (done_fire)
    );

    always_comb begin
        rsp_d    = rsp_q;
        hit_d    = hit_q;
        stamps_d = stamps_q;
        if (req_fire) begin
            rsp_d.uuid  = req_uuid;
            rsp_d.wid   = req_wid;
            rsp_d.tmask = FETCH_TMASK_W'(req_tmask);
            rsp_d.pid   = FETCH_PID_W'(req_pid);
            rsp_d.rd    = req_rd;
        end
        if (consume) begin
            hit_d = lane_hit;
            for (int i = 0; i < NUM_LANES; i++) begin
                stamps_d[i] = lane_hit[i] ? raster_stamps[i] : '0;
            end
        end else if (done_fire) begin
            hit_d    = '0;
            stamps_d = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rsp_q    <= '0;
            hit_q    <= '0;
            stamps_q <= '0;
        end else begin
            rsp_q    <= rsp_d;
            hit_q    <= hit_d;
            stamps_q <= stamps_d;
        end
    end

    assign write_uuid  = rsp_q.uuid;
    assign write_wid   = rsp_q.wid;
    assign write_tmask = hit_q;
    assign write_pid   = rsp_q.pid[PID_WIDTH-1:0];
    assign write_data  = stamps_q;

    assign rsp_uuid  = rsp_q.uuid;
    assign rsp_wid   = rsp_q.wid;
    assign rsp_tmask = rsp_q.tmask[NUM_LANES-1:0];
    assign rsp_pid   = rsp_q.pid[PID_WIDTH-1:0];
    assign rsp_rd    = rsp_q.rd;

    // Result per lane is the zero-extended stamp-present bit.
    always_comb begin
        rsp_data = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            rsp_data[i][0] = hit_q[i];
        end
    end

`ifdef RASTER_FETCH_PERF_EN
    logic [PERF_CTR_BITS-1:0] perf_stall_q, perf_stall_d;
    logic [PERF_CTR_BITS-1:0] perf_stamps_q, perf_stamps_d;
    logic [PERF_CTR_BITS-1:0] hit_cnt;

    always_comb begin
        hit_cnt = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            hit_cnt = hit_cnt + PERF_CTR_BITS'(lane_hit[i]);
        end
        perf_stall_d  = perf_stall_q;
        perf_stamps_d = perf_stamps_q;
        if (raster_ready && !raster_valid && !raster_done) begin
            perf_stall_d = perf_stall_q + 1'b1;
        end
        if (consume) begin
            perf_stamps_d = perf_stamps_q + hit_cnt;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_stall_q  <= '0;
            perf_stamps_q <= '0;
        end else begin
            perf_stall_q  <= perf_stall_d;
            perf_stamps_q <= perf_stamps_d;
        end
    end

    assign perf_stall_cycles = perf_stall_q;
    assign perf_stamps       = perf_stamps_q;
`endif

endmodule

// File: tb/tb_raster_stamp_fetch.sv
// Bench for raster_stamp_fetch with NUM_LANES=4: scoreboarded fetch
// transactions covering hit masks, exhaustion, stalls, backpressure and reset.
// Inputs driven and outputs sampled on the falling clock edge.
module tb_raster_stamp_fetch;
    import raster_stamp_fetch_pkg::*;

    localparam int NL = 4;
    localparam int PW = log2up(NUM_THREADS / NL);

    logic clk;
    logic reset;
    logic req_valid;
    logic [UUID_WIDTH-1:0] req_uuid;
    logic [NW_WIDTH-1:0] req_wid;
    logic [NL-1:0] req_tmask;
    logic [PW-1:0] req_pid;
    logic [NR_BITS-1:0] req_rd;
    logic req_ready;
    logic raster_valid;
    raster_stamp_t [NL-1:0] raster_stamps;
    logic [NL-1:0] raster_mask;
    logic raster_done;
    logic raster_ready;
    logic write_enable;
    logic [UUID_WIDTH-1:0] write_uuid;
    logic [NW_WIDTH-1:0] write_wid;
    logic [NL-1:0] write_tmask;
    logic [PW-1:0] write_pid;
    raster_stamp_t [NL-1:0] write_data;
    logic rsp_valid;
    logic [UUID_WIDTH-1:0] rsp_uuid;
    logic [NW_WIDTH-1:0] rsp_wid;
    logic [NL-1:0] rsp_tmask;
    logic [PW-1:0] rsp_pid;
    logic [NR_BITS-1:0] rsp_rd;
    logic [NL-1:0][XLEN-1:0] rsp_data;
    logic rsp_ready;
`ifdef RASTER_FETCH_PERF_EN
    logic [PERF_CTR_BITS-1:0] perf_stall_cycles;
    logic [PERF_CTR_BITS-1:0] perf_stamps;
`endif

    raster_stamp_fetch #(.CORE_ID(0), .NUM_LANES(NL), .PID_WIDTH(PW)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_uuid(req_uuid), .req_wid(req_wid),
        .req_tmask(req_tmask), .req_pid(req_pid), .req_rd(req_rd), .req_ready(req_ready),
        .raster_valid(raster_valid), .raster_stamps(raster_stamps), .raster_mask(raster_mask),
        .raster_done(raster_done), .raster_ready(raster_ready),
        .write_enable(write_enable), .write_uuid(write_uuid), .write_wid(write_wid),
        .write_tmask(write_tmask), .write_pid(write_pid), .write_data(write_data),
`ifdef RASTER_FETCH_PERF_EN
        .perf_stall_cycles(perf_stall_cycles), .perf_stamps(perf_stamps),
`endif
        .rsp_valid(rsp_valid), .rsp_uuid(rsp_uuid), .rsp_wid(rsp_wid), .rsp_tmask(rsp_tmask),
        .rsp_pid(rsp_pid), .rsp_rd(rsp_rd), .rsp_data(rsp_data), .rsp_ready(rsp_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [UUID_WIDTH-1:0] uuid;
        logic [NW_WIDTH-1:0]   wid;
        logic [NL-1:0]         tmask;
        logic [PW-1:0]         pid;
        logic [NR_BITS-1:0]    rd;
        logic [NL-1:0]         hit;
        raster_stamp_t [NL-1:0] wdata;
    } exp_t;

    typedef struct {
        int lat;
        bit timeout;
        bit rr_ok;
        logic we_at_rsp;
        logic [NL-1:0] wtmask;
        logic [UUID_WIDTH-1:0] wuuid;
        raster_stamp_t [NL-1:0] wdata;
        logic [UUID_WIDTH-1:0] ruuid;
        logic [NW_WIDTH-1:0] rwid;
        logic [NL-1:0] rtmask;
        logic [PW-1:0] rpid;
        logic [NR_BITS-1:0] rrd;
        logic [NL-1:0][XLEN-1:0] rdata;
        int unstable;
        int rdy_hold;
        int pulses;
        logic idle_after;
    } obs_t;

    exp_t exp_q[$];
    int vectors = 0;
    int miscompares = 0;
    int wr_pulses = 0;
    logic [PERF_CTR_BITS-1:0] exp_stall = '0;
    logic [PERF_CTR_BITS-1:0] exp_stamps = '0;

    always @(posedge clk) if (write_enable === 1'b1) wr_pulses++;

    // One fetch transaction starting at the current falling edge: request,
    // optional idle WAIT cycles, the raster beat, optional response hold, handshake.
    task automatic run_fetch(input logic [UUID_WIDTH-1:0] uuid, input logic [NW_WIDTH-1:0] wid,
                             input logic [NL-1:0] tmask, input logic [PW-1:0] pid,
                             input logic [NR_BITS-1:0] rd, input logic [NL-1:0] mask,
                             input int seed, input int delay, input bit v, input bit d,
                             input int hold, output obs_t ob);
        raster_stamp_t [NL-1:0] st;
        exp_t e;
        int w0;
        int t;
        for (int i = 0; i < NL; i++) begin
            st[i].pos_x = RASTER_POS_BITS'(seed * 3 + i);
            st[i].pos_y = RASTER_POS_BITS'(seed + 7 * i);
            st[i].mask  = 4'(i + 1);
        end
        e.uuid = uuid; e.wid = wid; e.tmask = tmask; e.pid = pid; e.rd = rd;
        e.hit = v ? (tmask & mask) : '0;
        for (int i = 0; i < NL; i++) e.wdata[i] = e.hit[i] ? st[i] : '0;
        exp_q.push_back(e);
        exp_stall  = exp_stall + PERF_CTR_BITS'(delay);
        exp_stamps = exp_stamps + PERF_CTR_BITS'($countones(e.hit));

        ob.timeout = 0; ob.rr_ok = 1; ob.unstable = 0; ob.rdy_hold = 0;
        req_valid = 1'b1; req_uuid = uuid; req_wid = wid; req_tmask = tmask;
        req_pid = pid; req_rd = rd;
        w0 = wr_pulses;
        @(negedge clk);
        req_valid = 1'b0;
        ob.lat = 1;
        for (int k = 0; k < delay; k++) begin
            if (raster_ready !== 1'b1) ob.rr_ok = 0;
            @(negedge clk);
            ob.lat++;
        end
        if (raster_ready !== 1'b1) ob.rr_ok = 0;
        raster_valid = v; raster_done = d; raster_mask = mask; raster_stamps = st;
        @(negedge clk);
        ob.lat++;
        raster_valid = 1'b0; raster_done = 1'b0;
        t = 0;
        while (rsp_valid !== 1'b1 && t < 20) begin
            @(negedge clk);
            ob.lat++; t++;
        end
        if (rsp_valid !== 1'b1) ob.timeout = 1;
        ob.we_at_rsp = write_enable; ob.wtmask = write_tmask; ob.wuuid = write_uuid;
        ob.wdata = write_data; ob.ruuid = rsp_uuid; ob.rwid = rsp_wid; ob.rtmask = rsp_tmask;
        ob.rpid = rsp_pid; ob.rrd = rsp_rd; ob.rdata = rsp_data;
        for (int k = 0; k < hold; k++) begin
            req_valid = 1'b1; req_uuid = ~uuid;
            @(negedge clk);
            if (req_ready !== 1'b0) ob.rdy_hold++;
            if (rsp_valid !== 1'b1 || rsp_uuid !== ob.ruuid || rsp_data !== ob.rdata ||
                rsp_tmask !== ob.rtmask || rsp_rd !== ob.rrd) ob.unstable++;
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        ob.pulses = wr_pulses - w0;
        ob.idle_after = req_ready;
    endtask

    task automatic test_reset();
        reset = 1'b1; req_valid = 0; req_uuid = '0; req_wid = '0; req_tmask = '0;
        req_pid = '0; req_rd = '0; raster_valid = 0; raster_stamps = '0; raster_mask = '0;
        raster_done = 0; rsp_ready = 0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        vectors++; if (req_ready !== 1'b1) begin miscompares++; $display("FAIL reset_req_ready: got %b want 1", req_ready); end
        vectors++; if (raster_ready !== 1'b0) begin miscompares++; $display("FAIL reset_raster_ready: got %b want 0", raster_ready); end
        vectors++; if (write_enable !== 1'b0) begin miscompares++; $display("FAIL reset_write_enable: got %b want 0", write_enable); end
        vectors++; if (rsp_valid !== 1'b0) begin miscompares++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
        vectors++; if (rsp_uuid !== '0 || rsp_tmask !== '0 || rsp_rd !== '0) begin
            miscompares++; $display("FAIL reset_fields: uuid %h tmask %b rd %0d want 0", rsp_uuid, rsp_tmask, rsp_rd); end
        vectors++; if (rsp_data !== '0 || write_tmask !== '0) begin
            miscompares++; $display("FAIL reset_data: rsp_data %h write_tmask %b want 0", rsp_data, write_tmask); end
        exp_stall = '0; exp_stamps = '0;
`ifdef RASTER_FETCH_PERF_EN
        vectors++; if (perf_stall_cycles !== exp_stall || perf_stamps !== exp_stamps) begin
            miscompares++; $display("FAIL reset_perf: stall %0d stamps %0d want 0", perf_stall_cycles, perf_stamps); end
`endif
    endtask

    task automatic test_stamp_hit();
        obs_t ob; exp_t e; logic [NL-1:0][XLEN-1:0] er;
        run_fetch(44'h0AB_CDEF_0123, 2'd1, 4'b1111, 1'b1, 5'd5, 4'b1011, 3, 0, 1'b1, 1'b0, 0, ob);
        e = exp_q.pop_front();
        for (int i = 0; i < NL; i++) er[i] = XLEN'(e.hit[i]);
        vectors++; if (ob.timeout || ob.lat != 2) begin miscompares++; $display("FAIL hit_latency: got %0d (timeout %0d) want 2", ob.lat, ob.timeout); end
        vectors++; if (ob.we_at_rsp !== 1'b1 || ob.pulses != 1) begin
            miscompares++; $display("FAIL hit_write_pulse: we %b pulses %0d want 1/1", ob.we_at_rsp, ob.pulses); end
        vectors++; if (ob.wtmask !== 4'b1011) begin miscompares++; $display("FAIL hit_write_tmask: got %b want 1011", ob.wtmask); end
        vectors++; if (ob.wdata !== e.wdata || ob.wuuid !== e.uuid) begin
            miscompares++; $display("FAIL hit_write_data: got %h want %h", ob.wdata, e.wdata); end
        vectors++; if (ob.rdata !== er) begin miscompares++; $display("FAIL hit_rsp_data: got %h want %h", ob.rdata, er); end
        vectors++; if (ob.ruuid !== e.uuid || ob.rwid !== e.wid || ob.rtmask !== e.tmask || ob.rpid !== e.pid || ob.rrd !== e.rd) begin
            miscompares++; $display("FAIL hit_rsp_echo: uuid %h tmask %b rd %0d want %h %b %0d", ob.ruuid, ob.rtmask, ob.rrd, e.uuid, e.tmask, e.rd); end
        vectors++; if (ob.idle_after !== 1'b1) begin miscompares++; $display("FAIL hit_idle_after: req_ready %b want 1", ob.idle_after); end
    endtask

    task automatic test_tmask_discard();
        obs_t ob; exp_t e; logic [NL-1:0][XLEN-1:0] er;
        run_fetch(44'h111, 2'd2, 4'b0110, 1'b0, 5'd9, 4'b1111, 5, 0, 1'b1, 1'b0, 0, ob);
        e = exp_q.pop_front();
        for (int i = 0; i < NL; i++) er[i] = XLEN'(e.hit[i]);
        vectors++; if (ob.wtmask !== e.hit || ob.wdata !== e.wdata) begin
            miscompares++; $display("FAIL discard_write: tmask %b data %h want %b %h", ob.wtmask, ob.wdata, e.hit, e.wdata); end
        vectors++; if (ob.rdata !== er || ob.rtmask !== 4'b0110) begin
            miscompares++; $display("FAIL discard_rsp: data %h tmask %b want %h 0110", ob.rdata, ob.rtmask, er); end
    endtask

    task automatic test_done_only();
        obs_t ob; exp_t e;
        run_fetch(44'h222, 2'd3, 4'b1111, 1'b1, 5'd2, 4'b1111, 7, 0, 1'b0, 1'b1, 0, ob);
        e = exp_q.pop_front();
        vectors++; if (ob.timeout || ob.lat != 2) begin miscompares++; $display("FAIL done_latency: got %0d want 2", ob.lat); end
        vectors++; if (ob.pulses != 0 || ob.we_at_rsp !== 1'b0) begin
            miscompares++; $display("FAIL done_no_write: pulses %0d we %b want 0", ob.pulses, ob.we_at_rsp); end
        vectors++; if (ob.rdata !== '0 || ob.ruuid !== e.uuid) begin
            miscompares++; $display("FAIL done_rsp: data %h uuid %h want 0 %h", ob.rdata, ob.ruuid, e.uuid); end
    endtask

    task automatic test_delayed_group();
        obs_t ob; exp_t e;
        run_fetch(44'h333, 2'd0, 4'b1111, 1'b0, 5'd17, 4'b1100, 9, 5, 1'b1, 1'b0, 0, ob);
        e = exp_q.pop_front();
        vectors++; if (!ob.rr_ok) begin miscompares++; $display("FAIL delay_raster_ready: dropped during wait, want held 1"); end
        vectors++; if (ob.timeout || ob.lat != 7) begin miscompares++; $display("FAIL delay_latency: got %0d want 7", ob.lat); end
        vectors++; if (ob.pulses != 1 || ob.wtmask !== e.hit) begin
            miscompares++; $display("FAIL delay_write: pulses %0d tmask %b want 1 %b", ob.pulses, ob.wtmask, e.hit); end
`ifdef RASTER_FETCH_PERF_EN
        vectors++; if (perf_stall_cycles !== exp_stall) begin miscompares++; $display("FAIL perf_stall: got %0d want %0d", perf_stall_cycles, exp_stall); end
        vectors++; if (perf_stamps !== exp_stamps) begin miscompares++; $display("FAIL perf_stamps: got %0d want %0d", perf_stamps, exp_stamps); end
`endif
    endtask

    task automatic test_rsp_backpressure();
        obs_t ob; exp_t e; logic [NL-1:0][XLEN-1:0] er;
        run_fetch(44'h444, 2'd1, 4'b1010, 1'b1, 5'd3, 4'b1110, 11, 0, 1'b1, 1'b0, 3, ob);
        e = exp_q.pop_front();
        for (int i = 0; i < NL; i++) er[i] = XLEN'(e.hit[i]);
        vectors++; if (ob.unstable != 0) begin miscompares++; $display("FAIL bp_payload_stable: %0d changed cycles want 0", ob.unstable); end
        vectors++; if (ob.rdy_hold != 0) begin miscompares++; $display("FAIL bp_req_ready: high %0d cycles want 0", ob.rdy_hold); end
        vectors++; if (ob.rdata !== er || ob.pulses != 1) begin
            miscompares++; $display("FAIL bp_rsp: data %h pulses %0d want %h 1", ob.rdata, ob.pulses, er); end
    endtask

    task automatic test_back_to_back();
        obs_t ob; exp_t e;
        run_fetch(44'h555, 2'd2, 4'b0011, 1'b0, 5'd4, 4'b0001, 13, 0, 1'b1, 1'b0, 0, ob);
        e = exp_q.pop_front();
        vectors++; if (ob.timeout || ob.lat != 2 || ob.ruuid !== e.uuid) begin
            miscompares++; $display("FAIL b2b_accept: lat %0d uuid %h want 2 %h", ob.lat, ob.ruuid, e.uuid); end
        vectors++; if (ob.wtmask !== 4'b0001) begin miscompares++; $display("FAIL b2b_tmask: got %b want 0001", ob.wtmask); end
    endtask

    task automatic test_valid_and_done();
        obs_t ob; exp_t e;
        run_fetch(44'h666, 2'd3, 4'b0001, 1'b0, 5'd6, 4'b0001, 15, 0, 1'b1, 1'b1, 0, ob);
        e = exp_q.pop_front();
        vectors++; if (ob.pulses != 1 || ob.wtmask !== 4'b0001 || ob.wdata !== e.wdata) begin
            miscompares++; $display("FAIL vd_write: pulses %0d tmask %b want 1 0001", ob.pulses, ob.wtmask); end
        vectors++; if (ob.rdata[0] !== 32'd1 || ob.rdata[3:1] !== '0) begin
            miscompares++; $display("FAIL vd_rsp_data: got %h want lane0=1 only", ob.rdata); end
    endtask

    task automatic test_reset_mid();
        int w0;
        int bad_rr;
        obs_t ob; exp_t e;
        req_valid = 1'b1; req_uuid = 44'h777; req_tmask = 4'b1111; req_rd = 5'd8;
        @(negedge clk);
        req_valid = 1'b0;
        vectors++; if (raster_ready !== 1'b1) begin miscompares++; $display("FAIL mid_in_wait: raster_ready %b want 1", raster_ready); end
        raster_valid = 1'b1; raster_mask = 4'b1111;
        w0 = wr_pulses;
        reset = 1'b1;
        #1;
        vectors++; if (raster_ready !== 1'b0) begin miscompares++; $display("FAIL mid_raster_ready: got %b want 0", raster_ready); end
        @(negedge clk);
        reset = 1'b0;
        vectors++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
            miscompares++; $display("FAIL mid_idle: rsp_valid %b req_ready %b want 0 1", rsp_valid, req_ready); end
        bad_rr = 0;
        repeat (3) begin
            @(negedge clk);
            if (raster_ready !== 1'b0 || rsp_valid !== 1'b0) bad_rr++;
        end
        raster_valid = 1'b0;
        vectors++; if (bad_rr != 0 || wr_pulses != w0) begin
            miscompares++; $display("FAIL mid_no_consume: bad %0d pulses %0d want 0 0", bad_rr, wr_pulses - w0); end
        vectors++; if (rsp_uuid !== '0) begin miscompares++; $display("FAIL mid_cleared: uuid %h want 0", rsp_uuid); end
        exp_stall = '0; exp_stamps = '0;
`ifdef RASTER_FETCH_PERF_EN
        vectors++; if (perf_stall_cycles !== exp_stall || perf_stamps !== exp_stamps) begin
            miscompares++; $display("FAIL mid_perf: stall %0d stamps %0d want 0", perf_stall_cycles, perf_stamps); end
`endif
        run_fetch(44'h888, 2'd0, 4'b1101, 1'b1, 5'd1, 4'b0111, 17, 0, 1'b1, 1'b0, 0, ob);
        e = exp_q.pop_front();
        vectors++; if (ob.timeout || ob.lat != 2 || ob.wtmask !== e.hit || ob.ruuid !== e.uuid) begin
            miscompares++; $display("FAIL mid_recover: lat %0d tmask %b want 2 %b", ob.lat, ob.wtmask, e.hit); end
    endtask

    initial begin
        test_reset();
        test_stamp_hit();
        test_tmask_discard();
        test_done_only();
        test_delayed_group();
        test_rsp_backpressure();
        test_back_to_back();
        test_valid_and_done();
        test_reset_mid();
        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
